// File: rtl/scalar_wb_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : scalar_wb_arbiter_pkg                                             |
// | Brief  : Shared constants and types for the scalar writeback/completion    |
// |          path (FU ids, register/word types, buffered writeback request).   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package scalar_wb_arbiter_pkg;

    localparam int NUM_SFU = 3;
    localparam int WORD_W  = 32;
    localparam int REG_W   = 5;
    localparam int FU_S_W  = 2;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    // FU id; the numeric value doubles as the holding-buffer / arbiter index.
    typedef enum logic [FU_S_W-1:0] {
        ALU    = 2'd0,
        LD_ST  = 2'd1,
        BRANCH = 2'd2
    } fu_scalar_t;

    typedef struct packed {
        logic     wen;
        regbits_t rd;
        word_t    data;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/scalar_wb_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : scalar_wb_arbiter_if                                              |
// | Brief  : FU completion inputs and RF-write / FUST-release outputs of the   |
// |          scalar writeback arbiter.                                         |
// |          slave  : arbiter side (takes fu_*, flush, wb_stall; drives wb_*,  |
// |                   rel_*, fu_ready)                                         |
// |          master : FU / RF / FUST side                                      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface scalar_wb_arbiter_if;
    import scalar_wb_arbiter_pkg::*;

    logic                       flush;
    logic                       wb_stall;
    logic [NUM_SFU-1:0]         fu_done;
    logic [NUM_SFU-1:0]         fu_wen;
    logic [NUM_SFU*REG_W-1:0]   fu_rd;
    logic [NUM_SFU*WORD_W-1:0]  fu_result;
    logic [NUM_SFU-1:0]         fu_ready;
    logic                       wb_valid;
    logic                       wb_wen;
    regbits_t                   wb_rd;
    word_t                      wb_data;
    logic                       rel_valid;
    fu_scalar_t                 rel_fu;

    modport slave (
        input  flush, wb_stall, fu_done, fu_wen, fu_rd, fu_result,
        output fu_ready, wb_valid, wb_wen, wb_rd, wb_data, rel_valid, rel_fu
    );

    modport master (
        output flush, wb_stall, fu_done, fu_wen, fu_rd, fu_result,
        input  fu_ready, wb_valid, wb_wen, wb_rd, wb_data, rel_valid, rel_fu
    );

endinterface
`default_nettype wire

// File: rtl/scalar_wb_arbiter_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rr_arbiter                                                        |
// | Brief  : N-way round-robin arbiter. Grants the first requester at or above |
// |          the pointer (wrapping), only while en is high. The pointer moves  |
// |          to one past the winner after a grant, and holds otherwise.        |
// | Ports  : CLK, nRST (sync, active low), req[N], en -> grant[N] one-hot,     |
// |          grant_idx, any_grant                                              |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic             CLK,
    input  wire logic             nRST,
    input  wire logic [N-1:0]     req,
    input  wire logic             en,
    output logic      [N-1:0]     grant,
    output logic      [IDX_W-1:0] grant_idx,
    output logic                  any_grant
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (en && !any_grant && req[IDX_W'(idx)]) begin
                grant[IDX_W'(idx)] = 1'b1;
                grant_idx          = IDX_W'(idx);
                any_grant          = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (any_grant) begin
            ptr_d = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/scalar_wb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : scalar_wb_arbiter                                                 |
// | Brief  : Scalar completion stage. One holding buffer per FU, round-robin   |
// |          arbitration onto the single RF write port, registered RF write    |
// |          and FUST release pulse.                                           |
// | Ports  : CLK, nRST (sync, active low)                                      |
// |          bus.slave : flush, wb_stall, fu_done/wen/rd/result -> fu_ready,   |
// |                      wb_valid, wb_wen, wb_rd, wb_data, rel_valid, rel_fu   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module scalar_wb_arbiter
    import scalar_wb_arbiter_pkg::*;
(
    input  wire logic            CLK,
    input  wire logic            nRST,
    scalar_wb_arbiter_if.slave   bus
);

    localparam int IDX_W = $clog2(NUM_SFU);

    wb_req_t            buf_q [NUM_SFU];
    wb_req_t            buf_d [NUM_SFU];
    logic [NUM_SFU-1:0] buf_v_q;
    logic [NUM_SFU-1:0] buf_v_d;

    logic [NUM_SFU-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               any_grant;
    logic [NUM_SFU-1:0] fu_ready;

    logic       wb_valid_q, wb_valid_d;
    logic       wb_wen_q,   wb_wen_d;
    regbits_t   wb_rd_q,    wb_rd_d;
    word_t      wb_data_q,  wb_data_d;
    fu_scalar_t rel_fu_q,   rel_fu_d;

    // Flush suppresses grants so nothing buffered leaks out past it.
    rr_arbiter #(
        .N     (NUM_SFU),
        .IDX_W (IDX_W)
    ) u_rr (
        .CLK       (CLK),
        .nRST      (nRST),
        .req       (buf_v_q),
        .en        (!bus.wb_stall && !bus.flush),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    // A buffer being drained this cycle can take the next result in the same cycle.
    assign fu_ready     = {NUM_SFU{!bus.flush}} & (~buf_v_q | grant);
    assign bus.fu_ready = fu_ready;

    always_comb begin
        buf_d   = buf_q;
        buf_v_d = buf_v_q;
        for (int i = 0; i < NUM_SFU; i++) begin
            if (bus.flush) begin
                buf_v_d[i] = 1'b0;
            end else begin
                if (grant[i]) begin
                    buf_v_d[i] = 1'b0;
                end
                if (bus.fu_done[i] && fu_ready[i]) begin
                    buf_v_d[i]    = 1'b1;
                    buf_d[i].wen  = bus.fu_wen[i];
                    buf_d[i].rd   = bus.fu_rd[i*REG_W +: REG_W];
                    buf_d[i].data = bus.fu_result[i*WORD_W +: WORD_W];
                end
            end
        end
    end

    // rd/data/fu hold their last value when nothing is granted.
    always_comb begin
        wb_valid_d = any_grant;
        wb_wen_d   = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        rel_fu_d   = rel_fu_q;
        if (any_grant) begin
            wb_wen_d  = buf_q[grant_idx].wen && (buf_q[grant_idx].rd != '0);
            wb_rd_d   = buf_q[grant_idx].rd;
            wb_data_d = buf_q[grant_idx].data;
            rel_fu_d  = fu_scalar_t'(grant_idx);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            buf_v_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_wen_q   <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            rel_fu_q   <= ALU;
            for (int i = 0; i < NUM_SFU; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            buf_v_q    <= buf_v_d;
            wb_valid_q <= wb_valid_d;
            wb_wen_q   <= wb_wen_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            rel_fu_q   <= rel_fu_d;
            buf_q      <= buf_d;
        end
    end

    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_wen    = wb_wen_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.rel_valid = wb_valid_q;
    assign bus.rel_fu    = rel_fu_q;

endmodule
`default_nettype wire
